// File: rtl/operand_gen.sv
// operand_gen: operand-pair stimulus generator for datapath energy characterisation.
// Each run emits `count` operand pairs, one per clock. The switching activity of the pairs
// is chosen by `mode`: zero, pseudo-random, walking-one or full-toggle.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   start, stop        start a run (sampled in IDLE only) / abort a run (stop wins)
//   mode[1:0]          00 zero, 01 random (LFSR), 10 walking-one, 11 toggle
//   count[15:0]        number of vectors in the run
//   in0_out, in1_out   registered operands; they hold the last vector while valid=0
//   valid, busy, done  new-vector strobe, run in progress, one-cycle completion pulse
//   toggle_count[23:0] accumulated operand bit flips within the run
//
// Configuration: define ACTIVITY_COUNT_EN to build the toggle counter. Without it,
// toggle_count is tied to zero.
module operand_gen #(
  parameter int unsigned WIDTH = 8,
  parameter logic [15:0] SEED0 = 16'hACE1,
  parameter logic [15:0] SEED1 = 16'h1D2C
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [15:0]      count,
  output logic [WIDTH-1:0] in0_out,
  output logic [WIDTH-1:0] in1_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [23:0]      toggle_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [1:0]  mode_q;
  logic [15:0] rem_q;    // vectors still to emit after the one currently shown
  logic [3:0]  pos_q;    // k mod WIDTH
  logic        phase_q;  // k[0]
  logic [15:0] lfsr0_q, lfsr1_q;

  // Fibonacci LFSR, taps 16,14,13,11, shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic             accept, emit_next;
  logic [1:0]       sel_mode;
  logic [3:0]       sel_pos;
  logic             sel_phase;
  logic [15:0]      sel_l0, sel_l1;
  logic [WIDTH-1:0] walk, gen0, gen1;

  assign accept    = (state_q == StIdle) && start && !stop;
  assign emit_next = (state_q == StRun) && !stop && (rem_q != 16'd0);

  // Generator inputs: in IDLE they describe vector 0 of a new run. In RUN they describe
  // the vector that follows the one currently shown.
  always_comb begin
    sel_mode  = mode;
    sel_pos   = 4'd0;
    sel_phase = 1'b0;
    sel_l0    = SEED0;
    sel_l1    = SEED1;
    if (state_q == StRun) begin
      sel_mode  = mode_q;
      sel_pos   = (pos_q == 4'(WIDTH - 1)) ? 4'd0 : pos_q + 4'd1;
      sel_phase = ~phase_q;
      sel_l0    = lfsr_step(lfsr0_q);
      sel_l1    = lfsr_step(lfsr1_q);
    end
  end

  always_comb begin
    walk = WIDTH'(1) << sel_pos;
    gen0 = '0;
    gen1 = '0;
    case (sel_mode)
      2'b01: begin
        gen0 = sel_l0[WIDTH-1:0];
        gen1 = sel_l1[WIDTH-1:0];
      end
      2'b10: begin
        gen0 = walk;
        gen1 = ~walk;
      end
      2'b11: begin
        gen0 = {WIDTH{sel_phase}};
        gen1 = {WIDTH{sel_phase}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      mode_q  <= 2'b00;
      rem_q   <= 16'd0;
      pos_q   <= 4'd0;
      phase_q <= 1'b0;
      lfsr0_q <= SEED0;
      lfsr1_q <= SEED1;
      in0_out <= '0;
      in1_out <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          lfsr0_q <= SEED0;
          lfsr1_q <= SEED1;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (accept) begin
            mode_q  <= mode;
            pos_q   <= 4'd0;
            phase_q <= 1'b0;
            if (count != 16'd0) begin
              state_q <= StRun;
              rem_q   <= count - 16'd1;
              in0_out <= gen0;
              in1_out <= gen1;
              valid   <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StRun: begin
          if (stop) begin
            state_q <= StIdle;
            valid   <= 1'b0;
            busy    <= 1'b0;
          end else if (rem_q == 16'd0) begin
            state_q <= StDone;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            rem_q   <= rem_q - 16'd1;
            pos_q   <= sel_pos;
            phase_q <= sel_phase;
            lfsr0_q <= sel_l0;
            lfsr1_q <= sel_l1;
            in0_out <= gen0;
            in1_out <= gen1;
            valid   <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ACTIVITY_COUNT_EN
  logic [WIDTH-1:0] diff0, diff1;
  logic [5:0]       flips;
  logic [24:0]      tc_sum;

  // Flips are measured against the currently shown vector, so vector 0 adds nothing.
  always_comb begin
    diff0 = gen0 ^ in0_out;
    diff1 = gen1 ^ in1_out;
    flips = 6'd0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      flips = flips + 6'(diff0[i]) + 6'(diff1[i]);
    end
    tc_sum = {1'b0, toggle_count} + 25'(flips);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      toggle_count <= 24'd0;
    end else if (accept) begin
      toggle_count <= 24'd0;
    end else if (emit_next) begin
      toggle_count <= tc_sum[24] ? 24'hFFFFFF : tc_sum[23:0];
    end
  end
`else
  assign toggle_count = 24'd0;
`endif

endmodule
